branch_resolve_unit: RTL and testbench

- Parametrised successor to the EX-stage branch comparator.
- Fully decodes RV32 conditional branches by funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU) plus JAL/JALR, computes the redirect target and detects direction mispredicts.
- Owns a PC-indexed table of 2-bit saturating counters that supplies the IF-stage direction prediction.
- Output is optionally registered and carries saturating performance counters.

---
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decode, direction, target, mispredict flush.
// Ports: clk/rst, stall, EX-slot inputs, IF lookup (pc_if/pred_taken_if),
//        resolution outputs (resolve_valid/br_taken/flush/redirect_pc), perf counters.
module branch_resolve_unit #(
  parameter int DWIDTH    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int OUT_REG   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 valid_ex,
  input  logic [DWIDTH-1:0]    instruction_ex,
  input  logic [DWIDTH-1:0]    pc_ex,
  input  logic [DWIDTH-1:0]    rs1,
  input  logic [DWIDTH-1:0]    rs2,
  input  logic [DWIDTH-1:0]    imm_ex,
  input  logic                 pred_taken_ex,
  input  logic [DWIDTH-1:0]    pc_if,
  output logic                 pred_taken_if,
  output logic                 resolve_valid,
  output logic                 br_taken,
  output logic                 flush,
  output logic [DWIDTH-1:0]    redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IW = $clog2(BHT_DEPTH);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_br;
  logic       is_jal;
  logic       is_jalr;
  logic       cf;
  logic       eq;
  logic       lt_s;
  logic       lt_u;
  logic       taken;
  logic       br_ok;
  logic       flush_next;
  logic       bht_we;

  logic [DWIDTH-1:0] seq_pc;
  logic [DWIDTH-1:0] target;
  logic [DWIDTH-1:0] redirect_next;

  logic [IW-1:0] idx_ex;
  logic [IW-1:0] idx_if;
  logic [1:0]    bht [BHT_DEPTH];

  logic unused;

  assign opcode  = instruction_ex[6:0];
  assign funct3  = instruction_ex[14:12];
  assign is_br   = (opcode == 7'b1100011);
  assign is_jal  = (opcode == 7'b1101111);
  assign is_jalr = (opcode == 7'b1100111);
  assign cf      = valid_ex & (is_br | is_jal | is_jalr);

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken = 1'b0;
    br_ok = 1'b0;
    unique case (1'b1)
      is_jal, is_jalr: taken = 1'b1;
      is_br: begin
        br_ok = 1'b1;
        case (funct3)
          3'b000:  taken = eq;
          3'b001:  taken = !eq;
          3'b100:  taken = lt_s;
          3'b101:  taken = !lt_s;
          3'b110:  taken = lt_u;
          3'b111:  taken = !lt_u;
          default: br_ok = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  assign seq_pc = pc_ex + DWIDTH'(4);

  // JALR target has bit 0 cleared; everything else is PC-relative.
  assign target = is_jalr ? ((rs1 + imm_ex) & ~DWIDTH'(1))
                          : (pc_ex + imm_ex);

  assign redirect_next = taken ? target : seq_pc;

  // Fetch never predicts a JALR target, so it always redirects.
  assign flush_next = cf & (is_jalr
                          | (is_jal & !pred_taken_ex)
                          | (is_br & (taken ^ pred_taken_ex)));

  assign idx_ex = pc_ex[IW+1:2];
  assign idx_if = pc_if[IW+1:2];

  assign pred_taken_if = bht[idx_if][1];

  assign bht_we = cf & is_br & br_ok & !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (bht_we) begin
      if (taken && bht[idx_ex] != 2'b11)
        bht[idx_ex] <= bht[idx_ex] + 2'd1;
      else if (!taken && bht[idx_ex] != 2'b00)
        bht[idx_ex] <= bht[idx_ex] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (!stall) begin
      if (cf && is_br && branch_count != '1)
        branch_count <= branch_count + 1'b1;
      if (flush_next && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          resolve_valid <= 1'b0;
          br_taken      <= 1'b0;
          flush         <= 1'b0;
          redirect_pc   <= '0;
        end else if (stall) begin
          // Pulses drop while held so each instruction flushes once.
          resolve_valid <= 1'b0;
          flush         <= 1'b0;
        end else begin
          resolve_valid <= cf;
          br_taken      <= cf & taken;
          flush         <= flush_next;
          redirect_pc   <= redirect_next;
        end
      end
    end else begin : g_comb
      assign resolve_valid = cf & !stall;
      assign br_taken      = cf & taken & !stall;
      assign flush         = flush_next & !stall;
      assign redirect_pc   = stall ? '0 : redirect_next;
    end
  endgenerate

  assign unused = ^{pc_if[DWIDTH-1:IW+2], pc_if[1:0],
                    instruction_ex[DWIDTH-1:15],
                    instruction_ex[11:7]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (OUT_REG=1, CNT_WIDTH=4).
// Vector table, randomized model comparison and hand-written corner sequences.
module tb_branch_resolve_unit;

  localparam int CW  = 4;
  localparam int CMX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          valid_ex;
  logic [31:0]   instruction_ex;
  logic [31:0]   pc_ex;
  logic [31:0]   rs1;
  logic [31:0]   rs2;
  logic [31:0]   imm_ex;
  logic          pred_taken_ex;
  logic [31:0]   pc_if;
  logic          pred_taken_if;
  logic          resolve_valid;
  logic          br_taken;
  logic          flush;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_resolve_unit #(
    .DWIDTH(32), .BHT_DEPTH(16), .OUT_REG(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid_ex(valid_ex),
    .instruction_ex(instruction_ex), .pc_ex(pc_ex),
    .rs1(rs1), .rs2(rs2), .imm_ex(imm_ex),
    .pred_taken_ex(pred_taken_ex), .pc_if(pc_if),
    .pred_taken_if(pred_taken_if), .resolve_valid(resolve_valid),
    .br_taken(br_taken), .flush(flush), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_bht [16];
  int          m_bc;
  int          m_mc;
  logic        e_rv, e_bt, e_fl;
  logic [31:0] e_rd;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op,
                                      input logic [2:0] f3);
    enc = {17'd0, f3, 5'd0, op};
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    bidx = int'((pc >> 2) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_bc = 0; m_mc = 0;
    e_rv = 0; e_bt = 0; e_fl = 0; e_rd = 0;
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic pr,
                      input logic st, input logic vl,
                      input logic [31:0] pif);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        isbr, isj, isjr, cf, tk, okf3, fl;
    logic [31:0] tgt, rd;
    instruction_ex = ins; pc_ex = pc; rs1 = a; rs2 = b;
    imm_ex = im; pred_taken_ex = pr; stall = st; valid_ex = vl;
    pc_if = pif;
    #1;
    chk("pred_taken_if", 32'(pred_taken_if), 32'(m_bht[bidx(pif)] >= 2));
    op = ins[6:0]; f3 = ins[14:12];
    isbr = (op == 7'h63); isj = (op == 7'h6F); isjr = (op == 7'h67);
    cf = vl && (isbr || isj || isjr);
    okf3 = 1;
    tk = 0;
    if (isj || isjr) tk = 1;
    else if (isbr) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) < $signed(b));
        3'd5: tk = !($signed(a) < $signed(b));
        3'd6: tk = (a < b);
        3'd7: tk = !(a < b);
        default: okf3 = 0;
      endcase
    end
    tgt = isjr ? ((a + im) & 32'hFFFF_FFFE) : (pc + im);
    rd = tk ? tgt : pc + 32'd4;
    fl = cf && (isjr || (isj && !pr) || (isbr && (tk != pr)));
    @(posedge clk);
    if (st) begin
      e_rv = 0; e_fl = 0;
    end else begin
      e_rv = cf; e_bt = cf && tk; e_fl = fl; e_rd = rd;
      if (cf && isbr) begin
        m_bc = (m_bc < CMX) ? m_bc + 1 : CMX;
        if (okf3) begin
          int i;
          i = bidx(pc);
          m_bht[i] = tk ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                        : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
        end
      end
      if (fl) m_mc = (m_mc < CMX) ? m_mc + 1 : CMX;
    end
    #1;
    chk("resolve_valid", 32'(resolve_valid), 32'(e_rv));
    chk("br_taken", 32'(br_taken), 32'(e_bt));
    chk("flush", 32'(flush), 32'(e_fl));
    if (e_fl) chk("redirect_pc", redirect_pc, e_rd);
    chk("branch_count", 32'(branch_count), 32'(m_bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic        pr;
    logic        vl;
    logic        x_rv;
    logic        x_bt;
    logic        x_fl;
    logic [31:0] x_rd;
  } vec_t;

  localparam logic [6:0] BR  = 7'h63;
  localparam logic [6:0] JAL = 7'h6F;
  localparam logic [6:0] JR  = 7'h67;
  localparam logic [6:0] ALU = 7'h33;

  vec_t tab [12];

  initial begin
    logic [31:0] ins, pc, a, b;
    int k, fp, bc0;
    logic [2:0] f3s [6];

    tab[0]  = '{enc(BR,3'd4), 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 1, 1, 1, 1, 32'h120};
    tab[1]  = '{enc(BR,3'd6), 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 1, 1, 0, 0, 32'h0};
    tab[2]  = '{enc(BR,3'd0), 32'h104, 32'd5, 32'd5, 32'h20, 1, 1, 1, 1, 0, 32'h0};
    tab[3]  = '{enc(BR,3'd1), 32'h108, 32'd5, 32'd5, 32'h20, 1, 1, 1, 0, 1, 32'h10C};
    tab[4]  = '{enc(BR,3'd5), 32'h10C, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 1, 1, 0, 0, 32'h0};
    tab[5]  = '{enc(BR,3'd7), 32'h110, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 0, 1, 1, 1, 1, 32'h100};
    tab[6]  = '{enc(JR,3'd0), 32'h114, 32'h1001, 32'd0, 32'd4, 1, 1, 1, 1, 1, 32'h1004};
    tab[7]  = '{enc(JAL,3'd0), 32'h118, 32'd0, 32'd0, 32'h40, 1, 1, 1, 1, 0, 32'h0};
    tab[8]  = '{enc(JAL,3'd0), 32'h11C, 32'd0, 32'd0, 32'h40, 0, 1, 1, 1, 1, 32'h15C};
    tab[9]  = '{enc(BR,3'd2), 32'h120, 32'd1, 32'd2, 32'h40, 1, 1, 1, 0, 1, 32'h124};
    tab[10] = '{enc(ALU,3'd0), 32'h124, 32'd1, 32'd1, 32'h40, 1, 1, 0, 0, 0, 32'h0};
    tab[11] = '{enc(BR,3'd0), 32'h128, 32'd1, 32'd1, 32'h40, 0, 0, 0, 0, 0, 32'h0};

    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd4;
    f3s[3] = 3'd5; f3s[4] = 3'd6; f3s[5] = 3'd7;

    rst = 1; stall = 0; valid_ex = 0; instruction_ex = 0; pc_ex = 0;
    rs1 = 0; rs2 = 0; imm_ex = 0; pred_taken_ex = 0; pc_if = 0;
    model_reset();
    #1;
    chk("rst_resolve_valid", 32'(resolve_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_branch_count", 32'(branch_count), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // vector table
    for (int i = 0; i < 12; i++) begin
      step(tab[i].ins, tab[i].pc, tab[i].a, tab[i].b, tab[i].im,
           tab[i].pr, 1'b0, tab[i].vl, tab[i].pc);
      chk($sformatf("tab%0d_rv", i), 32'(resolve_valid), 32'(tab[i].x_rv));
      chk($sformatf("tab%0d_bt", i), 32'(br_taken), 32'(tab[i].x_bt));
      chk($sformatf("tab%0d_fl", i), 32'(flush), 32'(tab[i].x_fl));
      if (tab[i].x_fl)
        chk($sformatf("tab%0d_rd", i), redirect_pc, tab[i].x_rd);
    end

    // randomized against the model
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k < 6) ins = enc(BR, f3s[k]);
      else if (k == 6) ins = enc(BR, 3'($urandom_range(2, 3)));
      else if (k == 7) ins = enc(JAL, 3'd0);
      else if (k == 8) ins = enc(JR, 3'd0);
      else ins = enc(ALU, 3'd0);
      pc = 32'h400 + 32'($urandom_range(0, 31)) * 4;
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 3)) - 32'd1;
      step(ins, pc, a, b, $urandom, 1'($urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 1) != 0) ? pc : 32'($urandom_range(0, 63)) * 4);
    end

    // asynchronous reset mid-stream, with a flush pending
    step(tab[0].ins, 32'h100, tab[0].a, tab[0].b, 32'h20, 0, 0, 1, 32'h0);
    chk("pre_rst_flush", 32'(flush), 32'd1);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_resolve_valid", 32'(resolve_valid), 32'd0);
    chk("arst_br_taken", 32'(br_taken), 32'd0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_redirect", redirect_pc, 32'd0);
    chk("arst_branch_count", 32'(branch_count), 32'd0);
    chk("arst_mispredict_count", 32'(mispredict_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pc_if = 32'(i) * 4;
      #1;
      chk($sformatf("arst_pred%0d", i), 32'(pred_taken_if), 32'd0);
    end
    @(posedge clk); #1;
    rst = 0;

    // loop training at 0x40: 01->10->11->11 then 10,01,00
    for (int i = 0; i < 6; i++) begin
      step(enc(BR, 3'd0), 32'h40, 32'd7, (i < 3) ? 32'd7 : 32'd8,
           32'h10, 0, 0, 1, 32'h40);
      pc_if = 32'h40;
      #1;
      chk($sformatf("train%0d", i), 32'(pred_taken_if),
          (i < 4) ? 32'd1 : 32'd0);
    end

    // reserved funct3 counts but leaves the entry alone
    step(enc(BR, 3'd0), 32'h90, 32'd1, 32'd1, 32'h10, 0, 0, 1, 32'h90);
    step(enc(BR, 3'd2), 32'h90, 32'd1, 32'd2, 32'h10, 0, 0, 1, 32'h90);
    pc_if = 32'h90;
    #1;
    chk("f3_010_bht", 32'(pred_taken_if), 32'd1);
    chk("f3_010_branch_count", 32'(branch_count), 32'd8);

    // BNE held under stall for 3 cycles
    fp = 0;
    bc0 = int'(branch_count);
    for (int i = 0; i < 5; i++) begin
      step(enc(BR, 3'd1), 32'h84, 32'd1, 32'd2, 32'h30, 0,
           (i < 3), (i < 4), 32'h84);
      fp += int'(flush);
      if (i == 3) chk("stall_redirect", redirect_pc, 32'hB4);
    end
    chk("stall_flush_pulses", 32'(fp), 32'd1);
    chk("stall_branch_delta", 32'(int'(branch_count) - bc0), 32'd1);
    chk("stall_mispredict", 32'(mispredict_count), 32'd5);
    step(enc(BR, 3'd1), 32'h84, 32'd3, 32'd3, 32'h30, 0, 0, 1, 32'h84);
    pc_if = 32'h84;
    #1;
    chk("stall_bht_once", 32'(pred_taken_if), 32'd0);

    // counter saturation
    for (int i = 0; i < 20; i++)
      step(enc(BR, 3'd0), 32'h88, 32'd4, 32'd4, 32'h8, 0, 0, 1, 32'h88);
    chk("sat_mispredict", 32'(mispredict_count), 32'hF);
    chk("sat_branch", 32'(branch_count), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
